// File: rtl/ddr_rd_cmd_responder.sv
// Responder for (base, length) DDR read commands: splits each command into
// per-word app-interface reads and returns the data through a FWFT FIFO.
module ddr_rd_cmd_responder #(
  parameter int DATA_W     = 512,
  parameter int ADR_W      = 32,
  parameter int LEN_W      = 16,
  parameter int ADR_STRIDE = 8,
  parameter int FIFO_DEPTH = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADR_W-1:0]  ddr_cmd_base_adr,
  input  logic [LEN_W-1:0]  ddr_cmd_length,
  input  logic              ddr_cmd_valid,
  output logic              ddr_cmd_ready,
  output logic              app_en,
  output logic [ADR_W-1:0]  app_addr,
  input  logic              app_rdy,
  input  logic [DATA_W-1:0] app_rd_data,
  input  logic              app_rd_data_valid,
  output logic [DATA_W-1:0] ddr_rd_data,
  output logic              ddr_rd_data_valid,
  input  logic              ddr_rd_data_ready,
  output logic              ddr_rd_done,
  output logic              err_overflow
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN} state_t;

  state_t             state_q, state_d;
  logic               app_en_q, app_en_d;
  logic [ADR_W-1:0]   app_addr_q, app_addr_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [LEN_W-1:0]   issued_q, issued_d;
  logic [LEN_W-1:0]   popped_q, popped_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [DATA_W-1:0]  fifo_mem [FIFO_DEPTH];

  logic               fire;
  logic               fifo_full;
  logic               fifo_empty;
  logic               pop;
  logic               push_req;
  logic               push;
  logic [LEN_W-1:0]   issued_inc;

  assign fire       = app_en_q & app_rdy;
  assign fifo_full  = (count_q == CNT_W'(FIFO_DEPTH));
  assign fifo_empty = (count_q == '0);
  assign pop        = ~fifo_empty & ddr_rd_data_ready;
  // Returns are only accepted while a command is in flight; stale returns
  // after a reset are dropped silently.
  assign push_req   = app_rd_data_valid & (state_q != S_IDLE);
  assign push       = push_req & (~fifo_full | pop);
  assign issued_inc = issued_q + LEN_W'(fire);

  always_comb begin
    state_d    = state_q;
    app_en_d   = app_en_q;
    app_addr_d = app_addr_q;
    len_d      = len_q;
    issued_d   = issued_q;
    popped_d   = popped_q + LEN_W'(pop);
    done_d     = 1'b0;
    err_d      = err_q | (push_req & fifo_full & ~pop);
    wr_ptr_d   = wr_ptr_q + PTR_W'(push);
    rd_ptr_d   = rd_ptr_q + PTR_W'(pop);
    count_d    = count_q + CNT_W'(push) - CNT_W'(pop);

    case (state_q)
      S_IDLE: begin
        app_en_d = 1'b0;
        if (ddr_cmd_valid) begin
          if (ddr_cmd_length == '0) begin
            done_d = 1'b1;
          end else begin
            state_d    = S_ISSUE;
            len_d      = ddr_cmd_length;
            issued_d   = '0;
            popped_d   = '0;
            app_en_d   = 1'b1;
            app_addr_d = ddr_cmd_base_adr;
          end
        end
      end
      S_ISSUE: begin
        issued_d = issued_inc;
        if (fire) begin
          app_addr_d = app_addr_q + ADR_W'(ADR_STRIDE);
        end
        if (issued_inc == len_q) begin
          state_d  = S_DRAIN;
          app_en_d = 1'b0;
        end else if (app_en_q && !app_rdy) begin
          app_en_d = 1'b1;
        end else begin
          // Credit covers both in-flight reads and words parked in the FIFO.
          app_en_d = ((issued_inc - popped_q) < LEN_W'(FIFO_DEPTH));
        end
      end
      S_DRAIN: begin
        if (popped_q == len_q) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d  = S_IDLE;
        app_en_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      app_en_q   <= 1'b0;
      app_addr_q <= '0;
      len_q      <= '0;
      issued_q   <= '0;
      popped_q   <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      app_en_q   <= app_en_d;
      app_addr_q <= app_addr_d;
      len_q      <= len_d;
      issued_q   <= issued_d;
      popped_q   <= popped_d;
      done_q     <= done_d;
      err_q      <= err_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

  // Storage carries no reset; emptiness is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_q] <= app_rd_data;
    end
  end

  assign ddr_cmd_ready     = (state_q == S_IDLE);
  assign app_en            = app_en_q;
  assign app_addr          = app_addr_q;
  assign ddr_rd_data_valid = ~fifo_empty;
  assign ddr_rd_data       = fifo_empty ? '0 : fifo_mem[rd_ptr_q];
  assign ddr_rd_done       = done_q;
  assign err_overflow      = err_q;

endmodule

// File: tb/tb_ddr_rd_cmd_responder.sv
// Self-checking bench for ddr_rd_cmd_responder: table of command scenarios
// plus hand-written back-to-back, overflow and mid-command reset sequences.
module tb_ddr_rd_cmd_responder;

  localparam int LAT = 10;

  logic         clk = 1'b0;
  logic         reset;
  logic [31:0]  ddr_cmd_base_adr;
  logic [15:0]  ddr_cmd_length;
  logic         ddr_cmd_valid;
  logic         ddr_cmd_ready;
  logic         app_en;
  logic [31:0]  app_addr;
  logic         app_rdy;
  logic [511:0] app_rd_data;
  logic         app_rd_data_valid;
  logic [511:0] ddr_rd_data;
  logic         ddr_rd_data_valid;
  logic         ddr_rd_data_ready;
  logic         ddr_rd_done;
  logic         err_overflow;

  always #5 clk = ~clk;

  ddr_rd_cmd_responder #(
    .DATA_W(512), .ADR_W(32), .LEN_W(16), .ADR_STRIDE(8), .FIFO_DEPTH(16)
  ) dut (
    .clk(clk),
    .reset(reset),
    .ddr_cmd_base_adr(ddr_cmd_base_adr),
    .ddr_cmd_length(ddr_cmd_length),
    .ddr_cmd_valid(ddr_cmd_valid),
    .ddr_cmd_ready(ddr_cmd_ready),
    .app_en(app_en),
    .app_addr(app_addr),
    .app_rdy(app_rdy),
    .app_rd_data(app_rd_data),
    .app_rd_data_valid(app_rd_data_valid),
    .ddr_rd_data(ddr_rd_data),
    .ddr_rd_data_valid(ddr_rd_data_valid),
    .ddr_rd_data_ready(ddr_rd_data_ready),
    .ddr_rd_done(ddr_rd_done),
    .err_overflow(err_overflow)
  );

  typedef struct {
    logic [31:0] base;
    logic [15:0] len;
    bit          toggle;
    int          hold;
    bit          stray;
    int          exp_stall;
    int          exp_done;
    bit          b2b;
  } vec_t;

  // Main-thread controls read by the memory/monitor process
  bit           rdy_mode = 1'b0;
  bit           inject   = 1'b0;
  int           clr_gen  = 0;

  // Monitor/memory-model state (written only by the model process)
  int           cyc = 0;
  int           seen_gen = 0;
  logic [31:0]  addr_log[$];
  int           fire_cyc[$];
  logic [511:0] rx_log[$];
  int           pend_t[$];
  logic [31:0]  pend_a[$];
  int           accept_cnt, accept_cyc, done_cnt, done_cyc;
  int           en_cycles, hold_viol, done_rdy_viol, notready_cnt;
  logic         prev_en, prev_rdy;
  logic [31:0]  prev_addr;

  int           errors = 0;
  int           checks = 0;
  string        tag = "init";
  logic [31:0]  exp_q[$];

  function automatic logic [511:0] word_of(input logic [31:0] a);
    return {16{a ^ 32'h5A5A_0000}};
  endfunction

  // Memory model and monitor: everything runs on the falling edge so that
  // values seen here are exactly those the DUT samples on the next rising edge.
  initial begin
    app_rdy = 1'b1;
    app_rd_data_valid = 1'b0;
    app_rd_data = '0;
    accept_cnt = 0; accept_cyc = 0; done_cnt = 0; done_cyc = 0;
    en_cycles = 0; hold_viol = 0; done_rdy_viol = 0; notready_cnt = 0;
    prev_en = 1'b0; prev_rdy = 1'b1; prev_addr = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (clr_gen != seen_gen) begin
        seen_gen = clr_gen;
        addr_log.delete(); fire_cyc.delete(); rx_log.delete();
        accept_cnt = 0; accept_cyc = 0; done_cnt = 0; done_cyc = 0;
        en_cycles = 0; hold_viol = 0; done_rdy_viol = 0; notready_cnt = 0;
      end
      app_rdy = rdy_mode ? ~app_rdy : 1'b1;
      app_rd_data_valid = 1'b0;
      app_rd_data = '0;
      if (pend_t.size() > 0 && pend_t[0] == cyc) begin
        app_rd_data_valid = 1'b1;
        app_rd_data = word_of(pend_a[0]);
        void'(pend_t.pop_front());
        void'(pend_a.pop_front());
      end
      if (inject) begin
        app_rd_data_valid = 1'b1;
        app_rd_data = {16{32'hBAD0_BAD0}};
      end
      if (ddr_cmd_valid && ddr_cmd_ready) begin
        accept_cnt++;
        accept_cyc = cyc;
      end
      if (app_en) en_cycles++;
      if (prev_en && !prev_rdy && (!app_en || app_addr != prev_addr)) hold_viol++;
      prev_en = app_en; prev_rdy = app_rdy; prev_addr = app_addr;
      if (app_en && app_rdy) begin
        addr_log.push_back(app_addr);
        fire_cyc.push_back(cyc);
        pend_t.push_back(cyc + LAT);
        pend_a.push_back(app_addr);
      end
      if (ddr_rd_data_valid && ddr_rd_data_ready) rx_log.push_back(ddr_rd_data);
      if (ddr_rd_done) begin
        done_cnt++;
        done_cyc = cyc;
        if (!ddr_cmd_ready) done_rdy_viol++;
      end
      if (!ddr_cmd_ready) notready_cnt++;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s/%s: got 0x%0h expected 0x%0h", tag, name, act, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_logs();
    clr_gen++;
    @(negedge clk);
  endtask

  task automatic send_cmd(input logic [31:0] base, input logic [15:0] len);
    @(posedge clk);
    #1;
    ddr_cmd_base_adr = base;
    ddr_cmd_length   = len;
    ddr_cmd_valid    = 1'b1;
    @(posedge clk);
    #1;
    ddr_cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int n);
    int k = 0;
    while (done_cnt < n && k < 1000) begin
      wait_cycles(1);
      k++;
    end
    if (done_cnt < n) chk("done_timeout", done_cnt, n);
  endtask

  task automatic wait_quiet();
    int k = 0;
    while (pend_t.size() > 0 && k < 200) begin
      wait_cycles(1);
      k++;
    end
    if (pend_t.size() > 0) chk("quiesce_timeout", pend_t.size(), 0);
    wait_cycles(2);
  endtask

  task automatic check_reset_values();
    chk("rst_cmd_ready", ddr_cmd_ready, 1);
    chk("rst_app_en", app_en, 0);
    chk("rst_app_addr", app_addr, 0);
    chk("rst_rd_valid", ddr_rd_data_valid, 0);
    chk("rst_rd_data_nz", (ddr_rd_data != '0), 0);
    chk("rst_done", ddr_rd_done, 0);
    chk("rst_overflow", err_overflow, 0);
  endtask

  task automatic verify(input int exp_done, input int exp_acc);
    int mism = 0;
    chk("req_count", addr_log.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < addr_log.size(); i++)
      if (addr_log[i] !== exp_q[i]) mism++;
    chk("addr_seq", mism, 0);
    chk("beat_count", rx_log.size(), exp_q.size());
    mism = 0;
    for (int i = 0; i < exp_q.size() && i < rx_log.size(); i++)
      if (rx_log[i] !== word_of(exp_q[i])) mism++;
    chk("data_seq", mism, 0);
    chk("done_pulses", done_cnt, exp_done);
    chk("accepts", accept_cnt, exp_acc);
    chk("overflow", err_overflow, 0);
    chk("addr_hold", hold_viol, 0);
    chk("done_with_ready", done_rdy_viol, 0);
    chk("cmd_ready_end", ddr_cmd_ready, 1);
    chk("fifo_empty_end", ddr_rd_data_valid, 0);
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int viol = 0;
    tag = $sformatf("vec%0d", idx);
    rdy_mode = v.toggle;
    ddr_rd_data_ready = (v.hold == 0);
    clear_logs();
    exp_q.delete();
    for (int i = 0; i < int'(v.len); i++) exp_q.push_back(v.base + 32'(i) * 32'd8);
    send_cmd(v.base, v.len);
    if (v.stray) begin
      wait_cycles(2);
      ddr_cmd_base_adr = 32'hDEAD_0000;
      ddr_cmd_length   = 16'd1;
      ddr_cmd_valid    = 1'b1;
      wait_cycles(1);
      ddr_cmd_valid = 1'b0;
      wait_cycles(2);
      ddr_cmd_valid = 1'b1;
      wait_cycles(1);
      ddr_cmd_valid = 1'b0;
    end
    if (v.hold > 0) begin
      wait_cycles(v.hold);
      chk("stall_issue", addr_log.size(), v.exp_stall);
      chk("stall_fifo_valid", ddr_rd_data_valid, 1);
      chk("stall_overflow", err_overflow, 0);
      ddr_rd_data_ready = 1'b1;
    end
    wait_done(v.exp_done);
    wait_cycles(15);
    verify(v.exp_done, 1);
    if (v.b2b) begin
      if (fire_cyc.size() == 0) viol++;
      else begin
        if (fire_cyc[0] != accept_cyc + 1) viol++;
        for (int i = 1; i < fire_cyc.size(); i++)
          if (fire_cyc[i] != fire_cyc[0] + i) viol++;
      end
      chk("issue_timing", viol, 0);
      chk("en_cycles", en_cycles, v.len);
    end
    if (v.len == 0) begin
      chk("len0_done_lat", done_cyc - accept_cyc, 1);
      chk("len0_ready_low", notready_cnt, 0);
      chk("len0_app_en", en_cycles, 0);
    end
    rdy_mode = 1'b0;
    $display("vec%0d base=0x%08h len=%0d reqs=%0d beats=%0d dones=%0d",
             idx, v.base, v.len, addr_log.size(), rx_log.size(), done_cnt);
  endtask

  initial begin
    vec_t vecs[5];
    vec_t v6;
    int   k;

    vecs[0] = '{base: 32'h0000_0100, len: 16'd4,  toggle: 1'b0, hold: 0,  stray: 1'b0, exp_stall: 0,  exp_done: 1, b2b: 1'b1};
    vecs[1] = '{base: 32'h0000_0200, len: 16'd0,  toggle: 1'b0, hold: 0,  stray: 1'b0, exp_stall: 0,  exp_done: 1, b2b: 1'b0};
    vecs[2] = '{base: 32'h0000_2000, len: 16'd20, toggle: 1'b0, hold: 60, stray: 1'b0, exp_stall: 16, exp_done: 1, b2b: 1'b0};
    vecs[3] = '{base: 32'h0000_0300, len: 16'd6,  toggle: 1'b1, hold: 0,  stray: 1'b1, exp_stall: 0,  exp_done: 1, b2b: 1'b0};
    vecs[4] = '{base: 32'hFFFF_FFF8, len: 16'd3,  toggle: 1'b0, hold: 0,  stray: 1'b0, exp_stall: 0,  exp_done: 1, b2b: 1'b1};
    v6      = '{base: 32'h0000_0600, len: 16'd2,  toggle: 1'b0, hold: 0,  stray: 1'b0, exp_stall: 0,  exp_done: 1, b2b: 1'b1};

    reset = 1'b0;
    ddr_cmd_base_adr = '0;
    ddr_cmd_length = '0;
    ddr_cmd_valid = 1'b0;
    ddr_rd_data_ready = 1'b1;
    wait_cycles(3);
    tag = "reset";
    check_reset_values();
    reset = 1'b1;
    wait_cycles(2);

    for (int i = 0; i < 5; i++) run_vec(vecs[i], i);

    // Back-to-back: second command raised in the cycle cmd_ready returns.
    tag = "b2b";
    clear_logs();
    exp_q = '{32'h0, 32'h8, 32'h10, 32'h40, 32'h48};
    send_cmd(32'h0, 16'd3);
    k = 0;
    while (!ddr_cmd_ready && k < 500) begin
      wait_cycles(1);
      k++;
    end
    chk("b2b_ready_rise", ddr_cmd_ready, 1);
    chk("b2b_done_with_rise", ddr_rd_done, 1);
    ddr_cmd_base_adr = 32'h40;
    ddr_cmd_length = 16'd2;
    ddr_cmd_valid = 1'b1;
    wait_cycles(1);
    ddr_cmd_valid = 1'b0;
    wait_done(2);
    wait_cycles(15);
    verify(2, 2);
    $display("b2b reqs=%0d beats=%0d dones=%0d", addr_log.size(), rx_log.size(), done_cnt);

    // Misbehaving memory: extra return while the FIFO is full.
    tag = "ovf";
    clear_logs();
    ddr_rd_data_ready = 1'b0;
    send_cmd(32'h800, 16'd17);
    k = 0;
    while ((addr_log.size() < 16 || pend_t.size() > 0) && k < 200) begin
      wait_cycles(1);
      k++;
    end
    wait_cycles(2);
    chk("ovf_stall_issue", addr_log.size(), 16);
    chk("ovf_pre", err_overflow, 0);
    inject = 1'b1;
    wait_cycles(1);
    inject = 1'b0;
    wait_cycles(3);
    chk("ovf_set", err_overflow, 1);
    ddr_rd_data_ready = 1'b1;
    wait_cycles(5);
    chk("ovf_sticky", err_overflow, 1);
    reset = 1'b0;
    wait_cycles(1);
    tag = "ovf_reset";
    check_reset_values();
    reset = 1'b1;
    wait_quiet();
    $display("ovf sequence reqs=%0d err_overflow=%0d", addr_log.size(), err_overflow);

    // Reset partway through an 8-word command, then a fresh command.
    tag = "midrst";
    clear_logs();
    send_cmd(32'h500, 16'd8);
    k = 0;
    while (addr_log.size() < 2 && k < 50) begin
      wait_cycles(1);
      k++;
    end
    chk("midrst_issued", (addr_log.size() >= 2), 1);
    reset = 1'b0;
    wait_cycles(1);
    check_reset_values();
    reset = 1'b1;
    wait_quiet();
    wait_cycles(5);
    chk("midrst_returns_ignored", ddr_rd_data_valid, 0);
    chk("midrst_no_done", done_cnt, 0);
    $display("midrst issued=%0d before reset", addr_log.size());
    run_vec(v6, 6);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
